kernel_buffer_pp: RTL and testbench

Parametrised kernel-weight buffer for the CNN core. It accepts KxK kernel coefficients as packed IN_W-bit words over a valid/ready stream and unpacks them into DATA_W-bit elements. It presents a complete kernel as one flat parallel bus to the convolution datapath. Two banks let kernel n+1 load while the datapath still holds kernel n.

---
 rtl/kernel_buffer_pp.sv | 148 ++++++++++++++
 tb/tb_kernel_buffer_pp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_buffer_pp.sv
// -----------------------------------------------------------------------------
// kernel_buffer_pp
//
// Kernel-weight buffer for the CNN core. Packed IN_W-bit words arrive on a
// valid/ready stream and are unpacked into DATA_W-bit elements. A complete
// KxK kernel is presented as one flat bus to the convolution datapath.
//
// Optional feature macro: KERNEL_BUF_PINGPONG_EN
//   defined   : two banks, so kernel n+1 loads while kernel n is presented
//   undefined : one bank; loading and presenting alternate
//
// Ports
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   s_valid  in   input word valid
//   s_ready  out  buffer can accept a word (decoded from registers only)
//   s_data   in   IN_W packed elements, lane j at [j*DATA_W +: DATA_W]
//   s_last   in   final word of a kernel
//   k_valid  out  a complete kernel is presented
//   k_ready  in   consumer releases the presented kernel
//   k_data   out  K*K*DATA_W, element i at [i*DATA_W +: DATA_W]
//   err_len  out  sticky framing error
//   err_clr  in   clears err_len (a new error in the same cycle wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A source holds valid and its payload until that edge. s_ready and
// k_valid depend only on bank state registers, never on s_valid or k_ready.
// -----------------------------------------------------------------------------
module kernel_buffer_pp #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int IN_W   = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic                    k_valid,
  input  logic                    k_ready,
  output logic [K*K*DATA_W-1:0]   k_data,
  output logic                    err_len,
  input  logic                    err_clr
);

  localparam int KK    = K * K;
  localparam int LANES = IN_W / DATA_W;
  localparam int WORDS = (KK + LANES - 1) / LANES;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);

  // Per-bank state machine: FREE -> FILL -> READY -> FREE
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } bank_st_e;

  bank_st_e             bank_st [2];
  logic [KK*DATA_W-1:0] mem     [2];
  logic [WW-1:0]        w;          // word index within the kernel being loaded
  logic                 wp;         // bank being loaded
  logic                 rp;         // bank being presented

  logic accept;
  logic release_k;
  logic at_end;
  logic done;
  logic bad;

  assign s_ready   = (bank_st[wp] != READY);
  assign k_valid   = (bank_st[rp] == READY);
  assign k_data    = mem[rp];

  assign accept    = s_valid && s_ready;
  assign release_k = k_valid && k_ready;
  assign at_end    = (w == W_LAST);
  // Framing: s_last must coincide exactly with the final word index.
  assign done      = accept && s_last && at_end;
  assign bad       = accept && (s_last != at_end);

  // Bank states, element storage, word index and the error flag.
  // When a release and an accept share an edge they always target different
  // banks: accept needs bank[wp] != READY while release needs bank[rp] == READY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      mem[0]     <= '0;
      mem[1]     <= '0;
      w          <= '0;
      err_len    <= 1'b0;
    end else begin
      if (release_k) begin
        bank_st[rp] <= FREE;
      end
      if (accept) begin
        // Element i comes from word i/LANES, lane i%LANES; lanes past the
        // last element simply have no destination and are dropped.
        for (int i = 0; i < KK; i++) begin
          if (w == WW'(i / LANES)) begin
            mem[wp][i*DATA_W +: DATA_W] <= s_data[(i % LANES)*DATA_W +: DATA_W];
          end
        end
        if (done) begin
          bank_st[wp] <= READY;
          w           <= '0;
        end else if (bad) begin
          // Partial kernel abandoned; the bank is reloaded from word 0.
          bank_st[wp] <= FREE;
          w           <= '0;
        end else begin
          bank_st[wp] <= FILL;
          w           <= w + WW'(1);
        end
      end
      if (bad) begin
        err_len <= 1'b1;
      end else if (err_clr) begin
        err_len <= 1'b0;
      end
    end
  end

`ifdef KERNEL_BUF_PINGPONG_EN
  // Write pointer advances on each completed kernel, read pointer on each
  // release, so banks are consumed in the order they were filled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      if (done) begin
        wp <= ~wp;
      end
      if (release_k) begin
        rp <= ~rp;
      end
    end
  end
`else
  // Single bank: bank 1 is never addressed and reduces away.
  assign wp = 1'b0;
  assign rp = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_buffer_pp.sv
// -----------------------------------------------------------------------------
// tb_kernel_buffer_pp
//
// Self-checking bench for kernel_buffer_pp (default parameters). Works for
// both builds: KERNEL_BUF_PINGPONG_EN defined or undefined.
// Expected kernels are pushed to exp_q when their last word is accepted and
// popped when the DUT releases a kernel (k_valid && k_ready).
// -----------------------------------------------------------------------------
module tb_kernel_buffer_pp;

  localparam int K      = 3;
  localparam int DATA_W = 8;
  localparam int IN_W   = 32;
  localparam int KK     = K * K;
  localparam int LANES  = IN_W / DATA_W;
  localparam int WORDS  = (KK + LANES - 1) / LANES;
  localparam int KW     = KK * DATA_W;

`ifdef KERNEL_BUF_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk     = 1'b0;
  logic            resetn  = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_last  = 1'b0;
  logic [IN_W-1:0] s_data  = '0;
  logic            k_ready = 1'b0;
  logic            err_clr = 1'b0;
  logic            s_ready;
  logic            k_valid;
  logic            err_len;
  logic [KW-1:0]   k_data;

  always #5 clk = ~clk;

  kernel_buffer_pp #(.K(K), .DATA_W(DATA_W), .IN_W(IN_W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_data  (k_data),
    .err_len (err_len),
    .err_clr (err_clr)
  );

  // ---------------- scoreboard ----------------
  logic [KW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] model(input logic [IN_W-1:0] wd [WORDS]);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < KK; i++) begin
      r[i*DATA_W +: DATA_W] = wd[i / LANES][(i % LANES)*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // Compare the presented kernel in the half-cycle before the release edge.
  always @(negedge clk) begin
    if (resetn && k_valid && k_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", KW'(exp_q.size()), KW'(1));
      end else begin
        chk("sb_kernel", k_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [IN_W-1:0] d, input logic last, output int stalls);
    stalls  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!s_ready) chk("s_ready_timeout", KW'(s_ready), KW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_kernel(input logic [IN_W-1:0] wd [WORDS], output int stalls);
    int s1;
    stalls = 0;
    for (int i = 0; i < WORDS; i++) begin
      send_word(wd[i], (i == WORDS - 1), s1);
      stalls += s1;
    end
    exp_q.push_back(model(wd));
  endtask

  task automatic rand_kernel(output logic [IN_W-1:0] wd [WORDS]);
    for (int i = 0; i < WORDS; i++) wd[i] = $urandom();
  endtask

  task automatic release_one();
    k_ready = 1'b1;
    @(posedge clk);
    #1;
    k_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) release_one();
    chk("drained", KW'(exp_q.size()), KW'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [IN_W-1:0] wa [WORDS];
  logic [IN_W-1:0] wb [WORDS];
  logic [IN_W-1:0] wc [WORDS];
  int st;

  initial begin
    // Reset state
    #2;
    chk("rst_s_ready", KW'(s_ready), KW'(1));
    chk("rst_k_valid", KW'(k_valid), KW'(0));
    chk("rst_k_data",  k_data,       KW'(0));
    chk("rst_err_len", KW'(err_len), KW'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Kernel A: fixed words, extra lanes of word 2 dropped
    wa = '{32'h04030201, 32'h08070605, 32'hDDCCBB09};
    load_kernel(wa, st);
    chk("a_k_valid", KW'(k_valid), KW'(1));
    chk("a_k_data",  k_data, KW'(72'h090807060504030201));
    chk("a_s_ready", KW'(s_ready), KW'(PP));

`ifdef KERNEL_BUF_PINGPONG_EN
    // Kernel B loads while A is held
    rand_kernel(wb);
    load_kernel(wb, st);
    chk("b_no_stall", KW'(st), KW'(0));
    chk("full_s_ready", KW'(s_ready), KW'(0));
    chk("a_held", k_data, KW'(72'h090807060504030201));
`endif

    // Next kernel stalls until A is released
    rand_kernel(wc);
    fork
      load_kernel(wc, st);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_s_ready", KW'(s_ready), KW'(0));
        release_one();
        chk("post_rel_s_ready", KW'(s_ready), KW'(1));
        chk("post_rel_k_valid", KW'(k_valid), KW'(PP));
`ifdef KERNEL_BUF_PINGPONG_EN
        chk("post_rel_b_data", k_data, model(wb));
`endif
      end
    join
    chk("c_k_valid", KW'(k_valid), KW'(1));
    drain();

    // Framing errors
    send_word(32'h11111111, 1'b0, st);
    send_word(32'h22222222, 1'b1, st);
    chk("err_early_last", KW'(err_len), KW'(1));
    chk("err_k_valid",    KW'(k_valid), KW'(0));
    chk("err_s_ready",    KW'(s_ready), KW'(1));
    @(posedge clk);
    #1;
    chk("err_sticky", KW'(err_len), KW'(1));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("err_clr", KW'(err_len), KW'(0));
    for (int i = 0; i < WORDS; i++) send_word($urandom(), 1'b0, st);
    chk("err_no_last",   KW'(err_len), KW'(1));
    chk("err_k_valid2",  KW'(k_valid), KW'(0));
    err_clr = 1'b1;
    send_word(32'h33333333, 1'b1, st);
    err_clr = 1'b0;
    chk("err_beats_clr", KW'(err_len), KW'(1));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    rand_kernel(wa);
    load_kernel(wa, st);
    chk("ok_after_err_valid", KW'(k_valid), KW'(1));
    chk("ok_after_err_data",  k_data, model(wa));
    chk("ok_after_err_flag",  KW'(err_len), KW'(0));
    drain();

`ifdef KERNEL_BUF_PINGPONG_EN
    // Release of A and final word of C on the same edge
    rand_kernel(wa);
    load_kernel(wa, st);
    rand_kernel(wc);
    send_word(wc[0], 1'b0, st);
    send_word(wc[1], 1'b0, st);
    s_valid = 1'b1;
    s_data  = wc[2];
    s_last  = 1'b1;
    k_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    k_ready = 1'b0;
    exp_q.push_back(model(wc));
    chk("sim_k_valid", KW'(k_valid), KW'(1));
    chk("sim_k_data",  k_data, model(wc));
    chk("sim_s_ready", KW'(s_ready), KW'(1));
    drain();
`endif

    // Asynchronous reset while a kernel is presented
    rand_kernel(wb);
    load_kernel(wb, st);
    #3 resetn = 1'b0;
    #1;
    chk("rst_pres_k_valid", KW'(k_valid), KW'(0));
    chk("rst_pres_s_ready", KW'(s_ready), KW'(1));
    chk("rst_pres_k_data",  k_data, KW'(0));
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;

    // Asynchronous reset after two words of a load
    send_word(32'hA5A5A5A5, 1'b0, st);
    send_word(32'h5A5A5A5A, 1'b0, st);
    #3 resetn = 1'b0;
    #1;
    chk("rst_load_k_data",  k_data, KW'(0));
    chk("rst_load_s_ready", KW'(s_ready), KW'(1));
    @(posedge clk);
    #1 resetn = 1'b1;

    // Fresh kernel starts at word 0
    rand_kernel(wc);
    load_kernel(wc, st);
    chk("fresh_k_valid", KW'(k_valid), KW'(1));
    chk("fresh_err_len", KW'(err_len), KW'(0));
    chk("fresh_k_data",  k_data, model(wc));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
